simple_dual_ram_be: RTL and testbench

//  Single-clock simple dual-port RAM: one write port with per-lane write masks, one read port with read enable and valid.

---
 rtl/simple_dual_ram_be.sv | 212 +++++++++++++++++++++
 tb/tb_simple_dual_ram_be.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_dual_ram_be.sv
// simple_dual_ram_be
//   Single-clock simple dual-port RAM with per-lane write masks, a registered
//   read port with valid pulse, optional extra output register, selectable
//   same-address collision policy and a post-reset zero-clear sweep.
//
// Ports
//   clk         rising-edge clock for all logic
//   rst         synchronous reset, active-high
//   waddr       write address ($clog2(DEPTH) bits)
//   write_data  write word (SIZE bits)
//   write_mask  per-lane write enable, lane i = bits [i*LANE +: LANE]
//   write_en    write strobe
//   raddr       read address ($clog2(DEPTH) bits)
//   read_en     read strobe
//   read_data   read result, holds its value between reads
//   read_valid  one-cycle pulse per accepted read
//   busy        high during reset and the clear sweep; user traffic ignored
module simple_dual_ram_be #(
  parameter int SIZE        = 8,
  parameter int DEPTH       = 8,
  parameter int LANE        = 8,
  parameter int OUT_REG     = 0,
  parameter int WRITE_FIRST = 0,
  parameter int CLEAR_INIT  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [SIZE-1:0]          write_data,
  input  logic [SIZE/LANE-1:0]     write_mask,
  input  logic                     write_en,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic                     read_en,
  output logic [SIZE-1:0]          read_data,
  output logic                     read_valid,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int NL = SIZE / LANE;

  // Full-width depth so the range check also works for non-power-of-two DEPTH.
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;

  // ---------------------------------------------------------------------------
  // Clear-sweep FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST_ADDR) begin
        state_d   = ST_READY;
        clr_ptr_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_INIT != 0) ? ST_CLEAR : ST_READY;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  assign busy = rst | (state_q == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Port qualification and array write-port mux
  // ---------------------------------------------------------------------------
  logic          sweep_we;
  logic          waddr_ok;
  logic          raddr_ok;
  logic          user_we;
  logic          rd_fire;
  logic [AW-1:0] rd_idx;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [SIZE-1:0] mem_wdata;
  logic [NL-1:0]   mem_wmask;

  always_comb begin
    sweep_we = (state_q == ST_CLEAR) & ~rst;
    waddr_ok = {1'b0, waddr} < DEPTH_W;
    raddr_ok = {1'b0, raddr} < DEPTH_W;
    user_we  = write_en & ~busy & waddr_ok & (|write_mask);
    rd_fire  = read_en & ~busy;
    // Out-of-range reads still clock the array at a safe index; the result
    // is forced to zero downstream.
    rd_idx   = raddr_ok ? raddr : '0;

    mem_we    = sweep_we | user_we;
    mem_addr  = sweep_we ? clr_ptr_q : waddr;
    mem_wdata = sweep_we ? '0 : write_data;
    mem_wmask = sweep_we ? '1 : write_mask;
  end

  // ---------------------------------------------------------------------------
  // Read stage 1: collision / range fix-up flags captured alongside the
  // registered array read.
  // ---------------------------------------------------------------------------
  logic            s1_valid_q,  s1_valid_d;
  logic            s1_zero_q,   s1_zero_d;
  logic            s1_bypass_q, s1_bypass_d;
  logic [SIZE-1:0] s1_wdata_q,  s1_wdata_d;
  logic [NL-1:0]   s1_wmask_q,  s1_wmask_d;
  logic [SIZE-1:0] s1_word;

  always_comb begin
    s1_valid_d  = rd_fire;
    s1_zero_d   = s1_zero_q;
    s1_bypass_d = s1_bypass_q;
    s1_wdata_d  = s1_wdata_q;
    s1_wmask_d  = s1_wmask_q;
    if (rd_fire) begin
      s1_zero_d   = ~raddr_ok;
      s1_bypass_d = (WRITE_FIRST != 0) & user_we & (waddr == raddr);
      s1_wdata_d  = write_data;
      s1_wmask_d  = write_mask;
    end
  end

  // s1_zero_q resets to 1 so read_data reads 0 after reset without putting a
  // reset on the array output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_zero_q   <= 1'b1;
      s1_bypass_q <= 1'b0;
      s1_wdata_q  <= '0;
      s1_wmask_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_zero_q   <= s1_zero_d;
      s1_bypass_q <= s1_bypass_d;
      s1_wdata_q  <= s1_wdata_d;
      s1_wmask_q  <= s1_wmask_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage, one array per lane. Write and registered read share a clocked
  // block so each maps onto block RAM; non-blocking semantics make a same-edge
  // read see the pre-write word, and write-first is layered on via s1_bypass.
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < NL; l++) begin : g_lane
    logic [LANE-1:0] mem_lane [DEPTH];
    logic [LANE-1:0] lane_rdata_q;

    always_ff @(posedge clk) begin
      if (mem_we && mem_wmask[l]) begin
        mem_lane[mem_addr] <= mem_wdata[l*LANE +: LANE];
      end
      if (rd_fire) begin
        lane_rdata_q <= mem_lane[rd_idx];
      end
    end

    assign s1_word[l*LANE +: LANE] =
      s1_zero_q                      ? '0 :
      (s1_bypass_q && s1_wmask_q[l]) ? s1_wdata_q[l*LANE +: LANE] :
                                       lane_rdata_q;
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic [SIZE-1:0] s2_data_q,  s2_data_d;
    logic            s2_valid_q, s2_valid_d;

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s2_data_q;
      if (s1_valid_q) begin
        s2_data_d = s1_word;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_data_q  <= s2_data_d;
        s2_valid_q <= s2_valid_d;
      end
    end

    assign read_data  = s2_data_q;
    assign read_valid = s2_valid_q;
  end else begin : g_out_direct
    // Stage-1 registers only change on an accepted read, so s1_word already
    // holds its value between reads.
    assign read_data  = s1_word;
    assign read_valid = s1_valid_q;
  end

endmodule

// File: tb/tb_simple_dual_ram_be.sv
// Bench for simple_dual_ram_be: two instances share one stimulus stream.
//   u_a: SIZE=16 LANE=8 DEPTH=8 OUT_REG=0 WRITE_FIRST=0
//   u_b: SIZE=16 LANE=8 DEPTH=6 OUT_REG=1 WRITE_FIRST=1
// A word-level model checks both every cycle; directed tasks pin literals.
module tb_simple_dual_ram_be;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic [2:0]  waddr = '0;
  logic [2:0]  raddr = '0;
  logic [15:0] write_data = '0;
  logic [1:0]  write_mask = '0;

  logic [15:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, busy_a, busy_b;

  always #5 clk = ~clk;

  simple_dual_ram_be #(
    .SIZE(16), .DEPTH(8), .LANE(8), .OUT_REG(0), .WRITE_FIRST(0), .CLEAR_INIT(1)
  ) u_a (
    .clk(clk), .rst(rst), .waddr(waddr), .write_data(write_data),
    .write_mask(write_mask), .write_en(write_en), .raddr(raddr),
    .read_en(read_en), .read_data(rdata_a), .read_valid(rvalid_a), .busy(busy_a)
  );

  simple_dual_ram_be #(
    .SIZE(16), .DEPTH(6), .LANE(8), .OUT_REG(1), .WRITE_FIRST(1), .CLEAR_INIT(1)
  ) u_b (
    .clk(clk), .rst(rst), .waddr(waddr), .write_data(write_data),
    .write_mask(write_mask), .write_en(write_en), .raddr(raddr),
    .read_en(read_en), .read_data(rdata_b), .read_valid(rvalid_b), .busy(busy_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [15:0] lane_merge(input logic [15:0] old_w,
                                             input logic [15:0] new_w,
                                             input logic [1:0]  m);
    lane_merge = old_w;
    if (m[0]) lane_merge[7:0]  = new_w[7:0];
    if (m[1]) lane_merge[15:8] = new_w[15:8];
  endfunction

  // ---------------------------------------------------------------------------
  // Model: per instance a word array, a remaining-sweep counter and a history
  // of read results per edge; the output shows the result from OUT_REG edges ago.
  // ---------------------------------------------------------------------------
  localparam int HLEN = 2048;
  logic [15:0] m_mem  [2][8];
  int          m_clr  [2];
  logic        m_hv   [2][HLEN];
  logic [15:0] m_hd   [2][HLEN];
  logic [15:0] m_last [2];
  int          cyc = 0;

  initial begin
    logic        s_rst, s_we, s_re;
    logic [2:0]  s_wa, s_ra;
    logic [15:0] s_wd, rd;
    logic [1:0]  s_wm;
    bit          rv;
    int          depth, lat, src;
    bit          e_v [2];
    bit          e_b [2];
    string       nm;
    for (int k = 0; k < 2; k++) begin
      m_clr[k]  = 0;
      m_last[k] = '0;
      for (int a = 0; a < 8; a++) m_mem[k][a] = '0;
      for (int i = 0; i < HLEN; i++) begin
        m_hv[k][i] = 1'b0;
        m_hd[k][i] = '0;
      end
    end
    forever begin
      @(posedge clk);
      s_rst = rst; s_we = write_en; s_re = read_en;
      s_wa = waddr; s_ra = raddr; s_wd = write_data; s_wm = write_mask;
      cyc++;
      if (cyc >= HLEN) begin
        $display("FAIL cycle_budget: got %0d cycles expected fewer than %0d", cyc, HLEN);
        $fatal(1);
      end
      for (int k = 0; k < 2; k++) begin
        depth = (k == 0) ? 8 : 6;
        lat   = (k == 0) ? 0 : 1;
        rv = 1'b0;
        rd = '0;
        if (s_rst) begin
          m_clr[k] = depth;
        end else if (m_clr[k] > 0) begin
          m_mem[k][depth - m_clr[k]] = '0;
          m_clr[k]--;
        end else begin
          if (s_re) begin
            rv = 1'b1;
            if (s_ra < depth) begin
              rd = m_mem[k][s_ra];
              if (k == 1 && s_we && s_wa == s_ra) rd = lane_merge(rd, s_wd, s_wm);
            end
          end
          if (s_we && s_wa < depth) m_mem[k][s_wa] = lane_merge(m_mem[k][s_wa], s_wd, s_wm);
        end
        m_hv[k][cyc] = rv;
        m_hd[k][cyc] = rd;
        src    = cyc - lat;
        e_v[k] = !s_rst && m_hv[k][src];
        if (s_rst)       m_last[k] = '0;
        else if (e_v[k]) m_last[k] = m_hd[k][src];
        e_b[k] = s_rst || (m_clr[k] > 0);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        nm = (k == 0) ? "A" : "B";
        chk($sformatf("%s read_valid @%0d", nm, cyc), (k == 0) ? rvalid_a : rvalid_b, e_v[k]);
        chk($sformatf("%s read_data @%0d", nm, cyc), (k == 0) ? rdata_a : rdata_b, m_last[k]);
        chk($sformatf("%s busy @%0d", nm, cyc), (k == 0) ? busy_a : busy_b, e_b[k]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus; inputs change on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [1:0] wm,
                       input logic re, input logic [2:0] ra);
    @(negedge clk);
    rst = r; write_en = we; waddr = wa; write_data = wd;
    write_mask = wm; read_en = re; raddr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0);
  endtask

  // Read (optionally with a simultaneous write); A answers after one edge, B after two.
  task automatic rd_chk(input string nm, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic [1:0] wm,
                        input logic [2:0] ra, input logic [15:0] ea, input logic [15:0] eb);
    drive(1'b0, we, wa, wd, wm, 1'b1, ra);
    @(posedge clk); #2;
    chk({nm, " A valid"}, rvalid_a, 1);
    chk({nm, " A data"}, rdata_a, ea);
    idle();
    @(posedge clk); #2;
    chk({nm, " B valid"}, rvalid_b, 1);
    chk({nm, " B data"}, rdata_b, eb);
  endtask

  // Counts edges after rst release until busy drops; optional junk traffic
  // is issued once the first entries have been swept.
  task automatic wait_ready(input string nm, input bit junk);
    int na = 0;
    int nb = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #2;
      if (!busy_a && na == 0) na = i;
      if (!busy_b && nb == 0) nb = i;
      if (na != 0 && nb != 0) break;
      if (junk && i >= 2 && i <= 5)
        drive(1'b0, 1'b1, 3'(i % 2), 16'hDEAD, 2'b11, 1'b1, 3'(i % 2));
      else
        idle();
    end
    chk({nm, " A busy cycles"}, na, 8);
    chk({nm, " B busy cycles"}, nb, 6);
  endtask

  initial begin
    int va;
    int vb;
    va = 0;
    vb = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    idle();
    wait_ready("post-reset", 1'b0);

    // Read every address once: each returns 0 with exactly one valid pulse.
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(i));
      else       idle();
      @(posedge clk); #2;
      va += int'(rvalid_a);
      vb += int'(rvalid_b);
    end
    chk("sweep readback A valid count", va, 8);
    chk("sweep readback B valid count", vb, 8);

    drive(1'b0, 1'b1, 3'd3, 16'h00A5, 2'b01, 1'b0, 3'd0);
    rd_chk("write-then-read @3", 1'b0, 3'd0, 16'h0, 2'b00, 3'd3, 16'h00A5, 16'h00A5);
    drive(1'b0, 1'b1, 3'd3, 16'hFFFF, 2'b00, 1'b0, 3'd0);
    rd_chk("mask0 no-op @3", 1'b0, 3'd0, 16'h0, 2'b00, 3'd3, 16'h00A5, 16'h00A5);

    drive(1'b0, 1'b1, 3'd5, 16'h1234, 2'b11, 1'b0, 3'd0);
    drive(1'b0, 1'b1, 3'd5, 16'hAB00, 2'b10, 1'b0, 3'd0);
    rd_chk("lane merge @5", 1'b0, 3'd0, 16'h0, 2'b00, 3'd5, 16'hAB34, 16'hAB34);

    drive(1'b0, 1'b1, 3'd2, 16'h1111, 2'b11, 1'b0, 3'd0);
    rd_chk("collision full @2", 1'b1, 3'd2, 16'h2222, 2'b11, 3'd2, 16'h1111, 16'h2222);
    rd_chk("after collision @2", 1'b0, 3'd0, 16'h0, 2'b00, 3'd2, 16'h2222, 16'h2222);
    rd_chk("collision lane0 @2", 1'b1, 3'd2, 16'h33CC, 2'b01, 3'd2, 16'h2222, 16'h22CC);

    drive(1'b0, 1'b1, 3'd7, 16'h7777, 2'b11, 1'b0, 3'd0);
    rd_chk("out-of-range @7", 1'b0, 3'd0, 16'h0, 2'b00, 3'd7, 16'h7777, 16'h0000);

    for (int i = 0; i < 6; i++)
      drive(1'b0, 1'b1, 3'(i), 16'h1000 + 16'(i), 2'b11, 1'b0, 3'd0);
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(i));
      else       idle();
      @(posedge clk); #2;
      chk($sformatf("back-to-back A valid i=%0d", i), rvalid_a, (i <= 5) ? 1 : 0);
      if (i <= 5) chk($sformatf("back-to-back A data i=%0d", i), rdata_a, 16'h1000 + i);
      chk($sformatf("back-to-back B valid i=%0d", i), rvalid_b, (i >= 1 && i <= 6) ? 1 : 0);
      if (i >= 1 && i <= 6) chk($sformatf("back-to-back B data i=%0d", i), rdata_b, 16'h1000 + i - 1);
    end

    // Reset lands while B's read is still in its output pipeline.
    drive(1'b0, 1'b1, 3'd5, 16'h5A5A, 2'b11, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd5);
    @(posedge clk); #2;
    chk("rst mid-read A valid", rvalid_a, 1);
    chk("rst mid-read A data", rdata_a, 16'h5A5A);
    drive(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0);
    @(posedge clk); #2;
    chk("rst mid-read B valid", rvalid_b, 0);
    chk("rst mid-read B data", rdata_b, 16'h0);
    chk("rst mid-read A data", rdata_a, 16'h0);
    chk("rst mid-read B busy", busy_b, 1);

    // Let the sweep advance four entries, then reset again mid-sweep.
    idle();
    repeat (4) @(posedge clk);
    drive(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0);
    idle();
    wait_ready("restarted sweep", 1'b1);
    rd_chk("after restart @0", 1'b0, 3'd0, 16'h0, 2'b00, 3'd0, 16'h0, 16'h0);
    rd_chk("after restart @1", 1'b0, 3'd0, 16'h0, 2'b00, 3'd1, 16'h0, 16'h0);
    rd_chk("after restart @5", 1'b0, 3'd0, 16'h0, 2'b00, 3'd5, 16'h0, 16'h0);

    repeat (2) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
